// File: rtl/ham74_decoder.sv
// ham74_decoder
// Registered single-error-correcting Hamming(7,4) decoder for the receive path.
// A codeword is accepted on every rising edge where in_valid is high. Its
// syndrome is computed, the bit it points at is flipped, and the four data bits
// are pulled from the corrected word. The result appears one cycle later.
// A saturating counter tracks how many accepted words needed a correction.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   e carries a codeword this cycle
//   e[6:0]     in   received codeword, Hamming position k is e[k-1]
//   clr_cnt    in   synchronous clear of corr_cnt (wins over an increment)
//   out_valid  out  p, c and err belong to the word accepted at the last edge
//   p[3:0]     out  syndrome {1'b0, s4, s2, s1} = erroneous position, 0 if clean
//   c[3:0]     out  corrected data {d4, d3, d2, d1}
//   err        out  syndrome was nonzero, a bit was flipped
//   corr_cnt   out  count of accepted words with nonzero syndrome, saturating
module ham74_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [6:0]       e,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic [3:0]       p,
  output logic [3:0]       c,
  output logic             err,
  output logic [CNT_W-1:0] corr_cnt
);

  logic [2:0] syn;
  logic [6:0] flip_mask;
  logic [6:0] e_fix;
  logic [3:0] data_fix;
  logic       syn_nz;
  logic       cnt_full;

  // Even-parity checks; each covers the positions whose index has that bit set.
  always_comb begin
    syn[0] = e[0] ^ e[2] ^ e[4] ^ e[6];
    syn[1] = e[1] ^ e[2] ^ e[5] ^ e[6];
    syn[2] = e[3] ^ e[4] ^ e[5] ^ e[6];
  end

  assign syn_nz = (syn != 3'd0);

  // One-hot decode of the syndrome onto bit positions 1..7. A zero syndrome
  // matches no position, so a clean word passes through untouched.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < 7; i++) begin
      flip_mask[i] = (syn == 3'(i + 1));
    end
  end

  assign e_fix    = e ^ flip_mask;
  assign data_fix = {e_fix[6], e_fix[5], e_fix[4], e_fix[2]};
  assign cnt_full = (corr_cnt == {CNT_W{1'b1}});

  // Result registers: updated only for accepted words, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= 4'd0;
      c         <= 4'd0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        p   <= {1'b0, syn};
        c   <= data_fix;
        err <= syn_nz;
      end
    end
  end

  // Corrected-word counter. Clear has priority over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
    end else if (in_valid && syn_nz && !cnt_full) begin
      corr_cnt <= corr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ham74_decoder.sv
// Directed testbench for ham74_decoder, built with CNT_W=2 so the counter
// saturation boundary is reachable in a handful of words.
module tb_ham74_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] e;
  logic       clr_cnt;
  logic       out_valid;
  logic [3:0] p;
  logic [3:0] c;
  logic       err;
  logic [1:0] corr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ham74_decoder #(.CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .e        (e),
    .clr_cnt  (clr_cnt),
    .out_valid(out_valid),
    .p        (p),
    .c        (c),
    .err      (err),
    .corr_cnt (corr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic v, input logic [6:0] w, input logic clr);
    @(negedge clk);
    in_valid = v;
    e        = w;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; e = '0; clr_cnt = 1'b0;
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov got %b want 0", out_valid); end
    n_tests++; if (p !== 4'd0)         begin n_fail++; $display("FAIL reset_p got %b want 0000", p); end
    n_tests++; if (c !== 4'd0)         begin n_fail++; $display("FAIL reset_c got %b want 0000", c); end
    n_tests++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_tests++; if (corr_cnt !== 2'd0)  begin n_fail++; $display("FAIL reset_cnt got %0d want 0", corr_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    step(1'b1, 7'b1100110, 1'b0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_ov got %b want 1", out_valid); end
    n_tests++; if (p !== 4'b0000)      begin n_fail++; $display("FAIL clean_p got %b want 0000", p); end
    n_tests++; if (c !== 4'b1101)      begin n_fail++; $display("FAIL clean_c got %b want 1101", c); end
    n_tests++; if (err !== 1'b0)       begin n_fail++; $display("FAIL clean_err got %b want 0", err); end
    n_tests++; if (corr_cnt !== 2'd0)  begin n_fail++; $display("FAIL clean_cnt got %0d want 0", corr_cnt); end
  endtask

  task automatic test_pos5();
    step(1'b1, 7'b1110110, 1'b0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pos5_ov got %b want 1", out_valid); end
    n_tests++; if (p !== 4'b0101)      begin n_fail++; $display("FAIL pos5_p got %b want 0101", p); end
    n_tests++; if (c !== 4'b1101)      begin n_fail++; $display("FAIL pos5_c got %b want 1101", c); end
    n_tests++; if (err !== 1'b1)       begin n_fail++; $display("FAIL pos5_err got %b want 1", err); end
    n_tests++; if (corr_cnt !== 2'd1)  begin n_fail++; $display("FAIL pos5_cnt got %0d want 1", corr_cnt); end
  endtask

  // Each single-bit error of 1100110, listed position 1..7.
  task automatic test_all_positions();
    logic [6:0] words [7];
    words[0] = 7'b1100111; words[1] = 7'b1100100; words[2] = 7'b1100010;
    words[3] = 7'b1101110; words[4] = 7'b1110110; words[5] = 7'b1000110;
    words[6] = 7'b0100110;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, words[k], 1'b0);
      n_tests++; if (p !== 4'(k + 1)) begin n_fail++; $display("FAIL pos%0d_p got %b want %b", k + 1, p, 4'(k + 1)); end
      n_tests++; if (c !== 4'b1101)   begin n_fail++; $display("FAIL pos%0d_c got %b want 1101", k + 1, c); end
      n_tests++; if (err !== 1'b1)    begin n_fail++; $display("FAIL pos%0d_err got %b want 1", k + 1, err); end
    end
  endtask

  task automatic test_extremes();
    step(1'b1, 7'b0000000, 1'b0);
    n_tests++; if (p !== 4'b0000) begin n_fail++; $display("FAIL zeros_p got %b want 0000", p); end
    n_tests++; if (c !== 4'b0000) begin n_fail++; $display("FAIL zeros_c got %b want 0000", c); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL zeros_err got %b want 0", err); end
    step(1'b1, 7'b1111111, 1'b0);
    n_tests++; if (p !== 4'b0000) begin n_fail++; $display("FAIL ones_p got %b want 0000", p); end
    n_tests++; if (c !== 4'b1111) begin n_fail++; $display("FAIL ones_c got %b want 1111", c); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL ones_err got %b want 0", err); end
  endtask

  // Valid words interleaved with gaps; during gaps e carries 0000001, which
  // would decode to p=0001 c=0000 if it were wrongly accepted.
  task automatic test_back_to_back();
    logic       vld   [8];
    logic [6:0] words [8];
    logic [3:0] exp_p [8];
    logic [3:0] exp_c [8];
    vld = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    words = '{7'b1100111, 7'b1101110, 7'b0000001, 7'b0100110,
              7'b0000001, 7'b0000001, 7'b1100110, 7'b1111111};
    exp_p = '{4'b0001, 4'b0100, 4'b0100, 4'b0111, 4'b0111, 4'b0111, 4'b0000, 4'b0000};
    exp_c = '{4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1111};
    for (int i = 0; i < 8; i++) begin
      step(vld[i], words[i], 1'b0);
      n_tests++; if (out_valid !== vld[i]) begin n_fail++; $display("FAIL b2b%0d_ov got %b want %b", i, out_valid, vld[i]); end
      n_tests++; if (p !== exp_p[i])       begin n_fail++; $display("FAIL b2b%0d_p got %b want %b", i, p, exp_p[i]); end
      n_tests++; if (c !== exp_c[i])       begin n_fail++; $display("FAIL b2b%0d_c got %b want %b", i, c, exp_c[i]); end
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step(1'b0, 7'b0000000, 1'b1);
    n_tests++; if (corr_cnt !== 2'd0) begin n_fail++; $display("FAIL cnt_clr got %0d want 0", corr_cnt); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7'b1110110, 1'b0);
      n_tests++; if (corr_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL cnt_sat%0d got %0d want %0d", i, corr_cnt, exp_cnt[i]); end
    end
    step(1'b0, 7'b1110110, 1'b0);
    n_tests++; if (corr_cnt !== 2'd3) begin n_fail++; $display("FAIL cnt_idle got %0d want 3", corr_cnt); end
    step(1'b1, 7'b1110110, 1'b1);
    n_tests++; if (corr_cnt !== 2'd0) begin n_fail++; $display("FAIL cnt_clr_prio got %0d want 0", corr_cnt); end
    n_tests++; if (err !== 1'b1)      begin n_fail++; $display("FAIL cnt_clr_err got %b want 1", err); end
    step(1'b1, 7'b1100110, 1'b0);
    n_tests++; if (corr_cnt !== 2'd0) begin n_fail++; $display("FAIL cnt_clean got %0d want 0", corr_cnt); end
    step(1'b1, 7'b1100100, 1'b0);
    n_tests++; if (corr_cnt !== 2'd1) begin n_fail++; $display("FAIL cnt_inc got %0d want 1", corr_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; e = 7'b0100110; clr_cnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_ov got %b want 0", out_valid); end
    n_tests++; if (p !== 4'd0)         begin n_fail++; $display("FAIL arst_p got %b want 0000", p); end
    n_tests++; if (c !== 4'd0)         begin n_fail++; $display("FAIL arst_c got %b want 0000", c); end
    n_tests++; if (err !== 1'b0)       begin n_fail++; $display("FAIL arst_err got %b want 0", err); end
    n_tests++; if (corr_cnt !== 2'd0)  begin n_fail++; $display("FAIL arst_cnt got %0d want 0", corr_cnt); end
    @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_hold_ov got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_rel_ov got %b want 0", out_valid); end
    n_tests++; if (p !== 4'd0)         begin n_fail++; $display("FAIL arst_rel_p got %b want 0000", p); end
    step(1'b1, 7'b1100111, 1'b0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_post_ov got %b want 1", out_valid); end
    n_tests++; if (p !== 4'b0001)      begin n_fail++; $display("FAIL arst_post_p got %b want 0001", p); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_pos5();
    test_all_positions();
    test_extremes();
    test_back_to_back();
    test_counter();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ham74_decoder.md
Name: ham74_decoder

Overview:
- Registered single-error-correcting Hamming(7,4) decoder.
- Accepts one 7-bit codeword per cycle and computes its 3-bit syndrome.
- Flips the erroneous bit when the syndrome is nonzero, then outputs the corrected 4-bit data word, syndrome and error flag one cycle later.
- Sits in the receive path after the channel/link model; also keeps a saturating count of corrected words for status reporting.

Parameters:
- CNT_W, 16, width of the corrected-word counter corr_cnt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  e carries a codeword this cycle.
- e  input  7  received codeword; Hamming position k (1..7) is e[k-1].
- clr_cnt  input  1  synchronous clear of corr_cnt.
- out_valid  output  1  p, c and err valid this cycle.
- p  output  4  syndrome, zero-extended: {1'b0, s4, s2, s1}; value = erroneous position 1..7, or 0 for no error.
- c  output  4  corrected data {d4, d3, d2, d1}.
- err  output  1  high when the syndrome is nonzero (a correction was applied).
- corr_cnt  output  CNT_W  number of accepted words with nonzero syndrome, saturating.

Behaviour:
- Codeword layout, positions 1..7 = e[0]..e[6]:
  - parity bits: p1 = e[0], p2 = e[1], p4 = e[3]
  - data bits: d1 = e[2], d2 = e[4], d3 = e[5], d4 = e[6]
- Syndrome, even parity:
  - s1 = e[0]^e[2]^e[4]^e[6]
  - s2 = e[1]^e[2]^e[5]^e[6]
  - s4 = e[3]^e[4]^e[5]^e[6]
  - S = {s4, s2, s1}
- Correction: if S != 0, invert e[S-1]; data is extracted from the corrected word. Errors on parity positions (1, 2, 4) leave data unchanged.
- Double-bit errors are miscorrected as single-bit errors. No detection of them is required, and p[3] is always 0.
- Latency: exactly 1 cycle. When in_valid is high at edge N, out_valid, p, c and err reflect that word after edge N.
- When in_valid is low at an edge:
  - out_valid goes low.
  - p, c and err hold their previous values.
  - corr_cnt is unchanged.
- No backpressure: a word is accepted every cycle in_valid is high, including back-to-back cycles.
- corr_cnt:
  - increments by 1 on each accepted word with S != 0.
  - saturates at 2^CNT_W - 1 (no wrap).
  - clr_cnt has priority: when clr_cnt is high, corr_cnt becomes 0 at that edge, even if an errored word is accepted in the same cycle.
- Reset (rst_n low, asynchronous assert, synchronous-safe release): out_valid = 0, p = 0, c = 0, err = 0, corr_cnt = 0.
- Reset asserted mid-stream discards any in-flight word. No output is produced for the word sampled at the edge where reset is released unless in_valid is high after release.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then in_valid=1, e=7'b1100110 (clean) -> next cycle out_valid=1, p=4'b0000, c=4'b1101, err=0, corr_cnt=0.
- e=7'b1110110 (error at position 5, data bit) -> p=4'b0101, c=4'b1101, err=1, corr_cnt=1.
- Single errors on each of the 7 positions of 1100110:
  - e=1100111 -> p=0001
  - e=1101110 -> p=0100
  - e=0100110 -> p=0111
  - every case -> c=1101, err=1.
- Back-to-back words every cycle with in_valid gaps interleaved -> out_valid mirrors in_valid delayed 1 cycle; p and c hold during gaps.
- e=7'b0000000 and e=7'b1111111 -> p=0000, c=0000 and c=1111 respectively, err=0.
- Counter boundaries, using CNT_W=2:
  - feed 5 errored words -> corr_cnt saturates at 3.
  - clr_cnt=1 together with an errored word -> corr_cnt=0.
  - async rst_n pulse mid-stream -> all outputs 0 immediately.
